led_flow_ctrl: RTL and testbench
================================

// Module: led_flow_ctrl
// PURPOSE
//  Parametrised LED pattern sequencer; generalises the fixed 4-LED shift light.
//  Programmable prescaler sets step rate; four run-time modes: rotate L, rotate R, ping-pong, bar fill.
//  Sits between board clock/reset and LED pins; en/mode/div come from switches or a control register.
// PARAMETERS
//  N_LED  8   number of LED outputs, >= 2
//  CNT_W  24  prescaler width; max step period 2^CNT_W cycles
// PORTS
//  clk   in   1      system clock, all logic on posedge
//  rst   in   1      synchronous reset, active-high
//  en    in   1      1 = prescaler runs; 0 = freeze counter and pattern
//  mode  in   2      00 rot-left, 01 rot-right, 10 ping-pong, 11 bar fill
//  div   in   CNT_W  step period minus 1 (in clk cycles)
//  led   out  N_LED  LED drive, bit 0 = LED0
//  step  out  1      one-cycle pulse, high in the cycle led takes a new value
//  wrap  out  1      one-cycle pulse, high when led returns to the mode seed
// BEHAVIOUR
//  Reset: cnt=0, mode_q=00, dir=left, pattern=seed(00)=...0001, step=0, wrap=0.
//  Seeds: modes 00/10/11 -> 0..01; mode 01 -> 10..0.
//  Prescaler: en=1 & cnt==div -> cnt<=0, tick; en=1 otherwise -> cnt+1; en=0 -> hold.
//   div=0 -> tick every enabled cycle. div lowered below cnt -> cnt runs to 2^CNT_W-1, wraps to 0, then matches.
//  Tick (pattern register updates on same edge, 1-cycle latency):
//   00: rotate left, MSB->bit0.  01: rotate right, bit0->MSB.
//   10: shift in dir; at bit N-1 dir<=right, at bit 0 dir<=left.
//       N=4: 0001,0010,0100,1000,0100,0010,0001,...
//   11: pattern<=(pattern<<1)|1 until all ones, then all zeros, then seed.
//       N=4: 0001,0011,0111,1111,0000,0001,...
//  step, wrap: registered; step=1 in the first cycle showing the new pattern.
//   wrap=1 in that same cycle iff the new pattern equals the mode seed.
//   Ping-pong: wrap only on the return to 0..01, not on reaching the MSB.
//  Mode change: mode!=mode_q -> next edge: mode_q<=mode, pattern<=seed(mode), cnt<=0, dir<=left.
//   No step/wrap pulse. Mode change beats a coincident tick. Applies with en=0 as well.
//  Illegal state: if pattern is not one-hot in modes 00/01/10 -> reload seed on next edge, no pulse.
//  rst beats en and mode change; rst mid-sequence restores reset state next edge.
// CONFIGURATION
//  LED_FLOW_PWM_EN defined:
//   Adds input duty[7:0] and an 8-bit free-running pwm_cnt (reset 0, increments every clk, ignores en).
//   led = pattern & {N_LED{pwm_cnt < duty}}. duty=0 -> dark; duty=255 -> on 255/256 cycles.
//   step/wrap are unaffected.
//  LED_FLOW_PWM_EN undefined: no duty port, no pwm_cnt; led = pattern.
// TESTING
//  rst 3 cycles -> led=0x01, step=0, wrap=0; hold en=0 for 20 cycles -> led stays 0x01.
//  N=4, mode=00, div=3, en=1 -> led 0001->0010->0100->1000->0001, one step per 4 clks; wrap with the 0001 step.
//  mode=10, div=0 -> 0001,0010,0100,1000,0100,0010,0001 on consecutive clks; one wrap, on the final 0001.
//  mode=11, div=1 -> 0001,0011,0111,1111,0000,0001 every 2 clks; switch mode to 01 mid-run -> next edge led=1000, cnt=0, no step.
//  Force pattern=0000 in mode 00 -> next edge 0001; div=0 with en toggling each clk -> one step per enabled clk.
//  PWM_EN, duty=64, pattern=0001 -> led[0] high for exactly 64 of each 256 clks; duty=0 -> led=0 throughout.

Source files
------------

// File: rtl/led_flow_ctrl.sv
// LED pattern sequencer: programmable prescaler driving rotate-left/right, ping-pong and bar-fill patterns.
// Optional feature macro: LED_FLOW_PWM_EN adds a duty input and 8-bit PWM dimming of the led outputs.
module led_flow_ctrl #(
  parameter int N_LED = 8,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div,
`ifdef LED_FLOW_PWM_EN
  input  logic [7:0]       duty,
`endif
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ROT_L = 2'b00,
    ROT_R = 2'b01,
    PING  = 2'b10,
    BAR   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_t;

  localparam logic [N_LED-1:0] SEED_LO = N_LED'(1);
  localparam logic [N_LED-1:0] SEED_HI = {1'b1, {(N_LED-1){1'b0}}};

  logic [CNT_W-1:0] cnt;
  mode_t            mode_q;
  mode_t            mode_in;
  dir_t             dir;
  dir_t             dir_nxt;
  logic [N_LED-1:0] pattern;
  logic [N_LED-1:0] pat_nxt;
  logic [N_LED-1:0] seed_cur;
  logic [N_LED-1:0] seed_new;
  logic             tick;
  logic             illegal;

  always_comb begin
    mode_in  = mode_t'(mode);
    seed_cur = (mode_q == ROT_R) ? SEED_HI : SEED_LO;
    seed_new = (mode_in == ROT_R) ? SEED_HI : SEED_LO;
    tick     = en && (cnt == div);
    // Bar fill legitimately holds multi-bit and all-zero patterns, so only the one-hot modes are policed.
    illegal  = (mode_q != BAR) && !$onehot(pattern);
  end

  always_comb begin
    pat_nxt = pattern;
    dir_nxt = dir;
    case (mode_q)
      ROT_L: pat_nxt = {pattern[N_LED-2:0], pattern[N_LED-1]};
      ROT_R: pat_nxt = {pattern[0], pattern[N_LED-1:1]};
      PING: begin
        pat_nxt = (dir == DIR_L) ? {pattern[N_LED-2:0], 1'b0} : {1'b0, pattern[N_LED-1:1]};
        if (pat_nxt[N_LED-1])
          dir_nxt = DIR_R;
        else if (pat_nxt[0])
          dir_nxt = DIR_L;
      end
      BAR: begin
        if (&pattern)
          pat_nxt = '0;
        else if (pattern == '0)
          pat_nxt = SEED_LO;
        else
          pat_nxt = {pattern[N_LED-2:0], 1'b1};
      end
      default: pat_nxt = SEED_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mode_q  <= ROT_L;
      dir     <= DIR_L;
      pattern <= SEED_LO;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else if (mode_in != mode_q) begin
      mode_q  <= mode_in;
      pattern <= seed_new;
      cnt     <= '0;
      dir     <= DIR_L;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (en)
        cnt <= tick ? '0 : cnt + 1'b1;
      if (illegal) begin
        pattern <= seed_cur;
        dir     <= DIR_L;
      end else if (tick) begin
        pattern <= pat_nxt;
        dir     <= dir_nxt;
        step    <= 1'b1;
        wrap    <= (pat_nxt == seed_cur);
      end
    end
  end

`ifdef LED_FLOW_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign led = pattern & {N_LED{pwm_cnt < duty}};
`else
  assign led = pattern;
`endif

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Scoreboard bench for led_flow_ctrl (N_LED=4): expected steps are queued with the stimulus and drained on step pulses.
module tb_led_flow_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] div;
  logic [N-1:0] led;
  logic         step;
  logic         wrap;
`ifdef LED_FLOW_PWM_EN
  logic [7:0]   duty;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_led[$];
  logic         exp_wrap[$];

  always #5 clk = ~clk;

  led_flow_ctrl #(.N_LED(N), .CNT_W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .div  (div),
`ifdef LED_FLOW_PWM_EN
    .duty (duty),
`endif
    .led  (led),
    .step (step),
    .wrap (wrap)
  );

  task automatic push(input logic [N-1:0] l, input logic w);
    exp_led.push_back(l);
    exp_wrap.push_back(w);
  endtask

  // Drain the queue: each step must carry the next expected pattern/wrap and arrive exactly period clks after the previous one.
  task automatic run_seq(input int period, input int budget, input string name);
    int cyc;
    int since;
    logic [N-1:0] el;
    logic ew;
    cyc = 0;
    since = 0;
    while (exp_led.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      since++;
      if (step) begin
        el = exp_led.pop_front();
        ew = exp_wrap.pop_front();
        checks++;
        if (led !== el) begin
          errors++;
          $display("FAIL %s led: got %b expected %b", name, led, el);
        end
        checks++;
        if (wrap !== ew) begin
          errors++;
          $display("FAIL %s wrap at led %b: got %b expected %b", name, el, wrap, ew);
        end
        checks++;
        if (since != period) begin
          errors++;
          $display("FAIL %s step gap: got %0d expected %0d", name, since, period);
        end
        since = 0;
      end else if (wrap !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s wrap without step: got %b expected 0", name, wrap);
      end
    end
    checks++;
    if (exp_led.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: got %0d pending steps expected 0", name, exp_led.size());
      exp_led.delete();
      exp_wrap.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    mode = 2'b00;
    div = 8'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 4'b0001) begin errors++; $display("FAIL reset led: got %b expected 0001", led); end
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL reset step: got %b expected 0", step); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset wrap: got %b expected 0", wrap); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0001 || step !== 1'b0) begin
        errors++;
        $display("FAIL freeze cycle %0d: got led %b step %b expected 0001 0", i, led, step);
      end
    end
  endtask

  task automatic test_rotate_left();
    div = 8'd3;
    en = 1'b1;
    push(4'b0010, 1'b0);
    push(4'b0100, 1'b0);
    push(4'b1000, 1'b0);
    push(4'b0001, 1'b1);
    run_seq(4, 40, "rotl");
  endtask

  task automatic test_rotate_right();
    en = 1'b0;
    mode = 2'b01;
    @(negedge clk);
    checks++;
    if (led !== 4'b1000 || step !== 1'b0) begin
      errors++;
      $display("FAIL rotr seed: got led %b step %b expected 1000 0", led, step);
    end
    div = 8'd0;
    en = 1'b1;
    push(4'b0100, 1'b0);
    push(4'b0010, 1'b0);
    push(4'b0001, 1'b0);
    push(4'b1000, 1'b1);
    run_seq(1, 20, "rotr");
  endtask

  task automatic test_pingpong();
    en = 1'b0;
    mode = 2'b10;
    @(negedge clk);
    checks++;
    if (led !== 4'b0001 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL ping seed: got led %b step %b wrap %b expected 0001 0 0", led, step, wrap);
    end
    div = 8'd0;
    en = 1'b1;
    push(4'b0010, 1'b0);
    push(4'b0100, 1'b0);
    push(4'b1000, 1'b0);
    push(4'b0100, 1'b0);
    push(4'b0010, 1'b0);
    push(4'b0001, 1'b1);
    run_seq(1, 30, "ping");
  endtask

  task automatic test_bar_mode_switch();
    en = 1'b0;
    mode = 2'b11;
    @(negedge clk);
    checks++;
    if (led !== 4'b0001 || step !== 1'b0) begin
      errors++;
      $display("FAIL bar seed: got led %b step %b expected 0001 0", led, step);
    end
    div = 8'd1;
    en = 1'b1;
    push(4'b0011, 1'b0);
    push(4'b0111, 1'b0);
    push(4'b1111, 1'b0);
    push(4'b0000, 1'b0);
    push(4'b0001, 1'b1);
    run_seq(2, 30, "bar");
    push(4'b0011, 1'b0);
    push(4'b0111, 1'b0);
    run_seq(2, 20, "bar2");
    @(negedge clk);
    // prescaler now one edge from a tick; the mode change must win
    mode = 2'b01;
    @(negedge clk);
    checks++;
    if (led !== 4'b1000 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL mode switch: got led %b step %b wrap %b expected 1000 0 0", led, step, wrap);
    end
    push(4'b0100, 1'b0);
    run_seq(2, 10, "after_switch");
  endtask

  task automatic test_illegal();
    en = 1'b0;
    mode = 2'b00;
    @(negedge clk);
    force dut.pattern = 4'b0000;
    #1;
    release dut.pattern;
    @(negedge clk);
    checks++;
    if (led !== 4'b0001 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL illegal reload: got led %b step %b wrap %b expected 0001 0 0", led, step, wrap);
    end
  endtask

  task automatic test_en_toggle();
    logic [N-1:0] cur;
    logic [N-1:0] el;
    logic ew;
    logic en_d;
    cur = 4'b0001;
    div = 8'd0;
    for (int i = 0; i < 10; i++) begin
      en_d = (i % 2 == 0);
      en = en_d;
      if (en_d) begin
        cur = {cur[N-2:0], cur[N-1]};
        push(cur, cur == 4'b0001);
      end
      @(negedge clk);
      checks++;
      if (step !== en_d) begin
        errors++;
        $display("FAIL en_toggle step %0d: got %b expected %b", i, step, en_d);
      end
      if (step && exp_led.size() > 0) begin
        el = exp_led.pop_front();
        ew = exp_wrap.pop_front();
        checks++;
        if (led !== el || wrap !== ew) begin
          errors++;
          $display("FAIL en_toggle data %0d: got %b/%b expected %b/%b", i, led, wrap, el, ew);
        end
      end
    end
    exp_led.delete();
    exp_wrap.delete();
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    div = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 4'b0001 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset mid: got led %b step %b wrap %b expected 0001 0 0", led, step, wrap);
    end
    rst = 1'b0;
    en = 1'b0;
  endtask

`ifdef LED_FLOW_PWM_EN
  task automatic test_pwm();
    int on_cnt;
    en = 1'b0;
    mode = 2'b00;
    duty = 8'd64;
    @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led[0]) on_cnt++;
    end
    checks++;
    if (on_cnt != 64) begin errors++; $display("FAIL pwm duty64: got %0d expected 64", on_cnt); end
    duty = 8'd0;
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led != '0) on_cnt++;
    end
    checks++;
    if (on_cnt != 0) begin errors++; $display("FAIL pwm duty0: got %0d expected 0", on_cnt); end
  endtask
`endif

  initial begin
`ifdef LED_FLOW_PWM_EN
    duty = 8'd255;
`endif
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_pingpong();
    test_bar_mode_switch();
    test_illegal();
    test_en_toggle();
    test_reset_mid();
`ifdef LED_FLOW_PWM_EN
    test_pwm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
